slow_mem_responder: RTL and testbench

Memory-side responder for the 128-bit line protocol that the L1/L2 caches use as initiators (mem_read / mem_write / mem_addr / mem_wdata / mem_rdata / mem_ready). It stores cache lines in an internal array and answers each request after a fixed, programmable latency with a one-cycle ready pulse. It stands in for the slow instruction or data memory behind each L2 cache, and exposes request counters and a protocol-error flag for performance and conformance checks.

---
 rtl/slow_mem_responder.sv | 97 +++++++++
 tb/tb_slow_mem_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/slow_mem_responder.sv
// Memory-side responder for the 128-bit cache line protocol: stores lines in an
// internal array and completes each request after a fixed latency with a ready pulse.
module slow_mem_responder #(
  parameter int LATENCY    = 6,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_ready,
  output logic         proto_err,
  output logic [15:0]  rd_cnt,
  output logic [15:0]  wr_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  state_t                state, state_nxt;
  logic [7:0]            cnt;
  logic [DEPTH_LOG2-1:0] idx;
  logic [127:0]          wdata_q;
  logic                  op_write;
  logic                  accept;
  logic                  commit;

  logic [127:0] mem_array [2**DEPTH_LOG2];

  // Upper address bits alias onto the stored lines and are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[27:DEPTH_LOG2];

  assign accept = (state == IDLE) && (mem_read || mem_write);
  assign commit = (state == BUSY) && (cnt == 8'd0);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the default assignment up front keeps this block free of latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_read || mem_write) state_nxt = BUSY;
      BUSY:    if (cnt == 8'd0)           state_nxt = DONE;
      DONE:                               state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  // Gated by rst so a reset landing in DONE never shows a completion.
  always_comb begin
    mem_ready = (state == DONE) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 8'd0;
      mem_rdata <= 128'h0;
      proto_err <= 1'b0;
      rd_cnt    <= 16'h0;
      wr_cnt    <= 16'h0;
    end else begin
      if (accept) begin
        cnt      <= CNT_LOAD;
        idx      <= mem_addr[DEPTH_LOG2-1:0];
        wdata_q  <= mem_wdata;
        op_write <= mem_write;
        if (mem_read && mem_write) proto_err <= 1'b1;
      end else if (state == BUSY && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end

      if (commit) begin
        if (op_write) begin
          if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
        end else begin
          mem_rdata <= mem_array[idx];
          if (rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
        end
      end
    end
  end

  // NOTE: the line store has no reset so it maps onto RAM and survives rst.
  always_ff @(posedge clk) begin
    if (!rst && commit && op_write) mem_array[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_slow_mem_responder.sv
// Directed bench for slow_mem_responder: three instances at LATENCY 6, 1 and 255.
module tb_slow_mem_responder;

  logic         clk = 1'b0;
  logic         rst       [3];
  logic         mem_read  [3];
  logic         mem_write [3];
  logic [27:0]  mem_addr  [3];
  logic [127:0] mem_wdata [3];
  logic [127:0] mem_rdata [3];
  logic         mem_ready [3];
  logic         proto_err [3];
  logic [15:0]  rd_cnt    [3];
  logic [15:0]  wr_cnt    [3];

  int n_vec = 0;
  int n_err = 0;

  localparam logic [127:0] LINE_A = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;
  localparam logic [127:0] LINE_B = 128'h1357_9BDF_2468_ACE0_1111_2222_3333_4444;
  localparam logic [127:0] OLD3   = 128'hCAFE_0000_0000_0000_0000_0000_0000_0003;
  localparam logic [127:0] NEW3   = 128'hBAD0_0000_0000_0000_0000_0000_0000_0003;

  always #5 clk = ~clk;

  slow_mem_responder #(.LATENCY(6), .DEPTH_LOG2(8)) dut (
    .clk(clk), .rst(rst[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .mem_ready(mem_ready[0]), .proto_err(proto_err[0]), .rd_cnt(rd_cnt[0]), .wr_cnt(wr_cnt[0])
  );

  slow_mem_responder #(.LATENCY(1), .DEPTH_LOG2(8)) dut_l1 (
    .clk(clk), .rst(rst[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .mem_ready(mem_ready[1]), .proto_err(proto_err[1]), .rd_cnt(rd_cnt[1]), .wr_cnt(wr_cnt[1])
  );

  slow_mem_responder #(.LATENCY(255), .DEPTH_LOG2(8)) dut_l255 (
    .clk(clk), .rst(rst[2]), .mem_read(mem_read[2]), .mem_write(mem_write[2]),
    .mem_addr(mem_addr[2]), .mem_wdata(mem_wdata[2]), .mem_rdata(mem_rdata[2]),
    .mem_ready(mem_ready[2]), .proto_err(proto_err[2]), .rd_cnt(rd_cnt[2]), .wr_cnt(wr_cnt[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request, return edges from acceptance to the ready pulse (-1 on timeout).
  task automatic xact(input int d, input logic rd, input logic wr, input logic [27:0] addr,
                      input logic [127:0] data, output int lat);
    mem_read[d]  = rd;
    mem_write[d] = wr;
    mem_addr[d]  = addr;
    mem_wdata[d] = data;
    tick();
    lat = -1;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (mem_ready[d]) begin
        lat = i;
        break;
      end
    end
    mem_read[d]  = 1'b0;
    mem_write[d] = 1'b0;
    tick();
  endtask

  initial begin
    int           lat;
    int           gap;
    int           pulses;
    logic [127:0] first_rdata;
    logic [127:0] data_x;

    for (int d = 0; d < 3; d++) begin
      rst[d]       = 1'b1;
      mem_read[d]  = 1'b0;
      mem_write[d] = 1'b0;
      mem_addr[d]  = 28'h0;
      mem_wdata[d] = 128'h0;
    end
    tick();
    tick();
    check("rst_ready",     128'(mem_ready[0]), 128'h0);
    check("rst_rdata",     mem_rdata[0],       128'h0);
    check("rst_rd_cnt",    128'(rd_cnt[0]),    128'h0);
    check("rst_wr_cnt",    128'(wr_cnt[0]),    128'h0);
    check("rst_proto_err", 128'(proto_err[0]), 128'h0);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;

    // Write then read back at LATENCY 6.
    xact(0, 1'b0, 1'b1, 28'h0000012, LINE_A, lat);
    check("wr_latency", 128'(lat),       128'd6);
    check("wr_cnt_1",   128'(wr_cnt[0]), 128'd1);
    check("ready_one_cycle", 128'(mem_ready[0]), 128'h0);
    xact(0, 1'b1, 1'b0, 28'h0000012, 128'h0, lat);
    check("rd_latency", 128'(lat),       128'd6);
    check("rd_data",    mem_rdata[0],    LINE_A);
    check("rd_cnt_1",   128'(rd_cnt[0]), 128'd1);

    // Aliasing: 0x105 and 0x005 share index 5.
    xact(0, 1'b0, 1'b1, 28'h0000105, 128'h1, lat);
    xact(0, 1'b1, 1'b0, 28'h0000005, 128'h0, lat);
    check("alias_data", mem_rdata[0], 128'h1);
    check("proto_err_clear", 128'(proto_err[0]), 128'h0);

    // Read and write together: handled as a write and flagged.
    xact(0, 1'b1, 1'b1, 28'h0000007, 128'hA5, lat);
    check("proto_err_set", 128'(proto_err[0]), 128'h1);
    check("proto_wr_cnt",  128'(wr_cnt[0]),    128'd3);
    check("proto_rd_cnt",  128'(rd_cnt[0]),    128'd2);
    xact(0, 1'b1, 1'b0, 28'h0000007, 128'h0, lat);
    check("proto_is_write", mem_rdata[0],       128'hA5);
    check("proto_sticky",   128'(proto_err[0]), 128'h1);

    // Inputs scrambled every BUSY cycle must not disturb the latched request.
    data_x       = LINE_B;
    mem_write[0] = 1'b1;
    mem_addr[0]  = 28'h0000020;
    mem_wdata[0] = data_x;
    tick();
    mem_write[0] = 1'b0;
    lat = -1;
    for (int i = 1; i <= 400; i++) begin
      mem_addr[0]  = 28'($urandom);
      mem_wdata[0] = {$urandom, $urandom, $urandom, $urandom};
      tick();
      if (mem_ready[0]) begin
        lat = i;
        break;
      end
    end
    tick();
    check("scramble_latency", 128'(lat),    128'd6);
    check("rdata_held",       mem_rdata[0], 128'hA5);
    xact(0, 1'b1, 1'b0, 28'h0000020, 128'h0, lat);
    check("scramble_data", mem_rdata[0], data_x);

    // Read held through the ready cycle: re-accepted, pulses LATENCY+2 apart.
    mem_read[0] = 1'b1;
    mem_addr[0] = 28'h0000012;
    tick();
    lat = -1;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (mem_ready[0]) begin
        lat = i;
        break;
      end
    end
    first_rdata = mem_rdata[0];
    mem_addr[0] = 28'h0000005;
    gap = -1;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (mem_ready[0]) begin
        gap = i;
        break;
      end
    end
    mem_read[0] = 1'b0;
    tick();
    check("held_first_latency", 128'(lat),       128'd6);
    check("held_first_data",    first_rdata,     LINE_A);
    check("held_spacing",       128'(gap),       128'd8);
    check("held_second_data",   mem_rdata[0],    128'h1);
    check("held_rd_cnt",        128'(rd_cnt[0]), 128'd6);
    check("held_wr_cnt",        128'(wr_cnt[0]), 128'd4);

    // Reset landing in the DONE cycle suppresses ready and clears status.
    mem_read[0] = 1'b1;
    mem_addr[0] = 28'h0000012;
    tick();
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (mem_ready[0]) break;
    end
    rst[0]      = 1'b1;
    mem_read[0] = 1'b0;
    #1;
    check("ready_masked_by_rst", 128'(mem_ready[0]), 128'h0);
    tick();
    rst[0] = 1'b0;
    check("rst2_rd_cnt",    128'(rd_cnt[0]),    128'h0);
    check("rst2_wr_cnt",    128'(wr_cnt[0]),    128'h0);
    check("rst2_proto_err", 128'(proto_err[0]), 128'h0);
    check("rst2_rdata",     mem_rdata[0],       128'h0);
    xact(0, 1'b1, 1'b0, 28'h0000012, 128'h0, lat);
    check("mem_survives_rst", mem_rdata[0], LINE_A);

    // LATENCY 1: ready on the first edge after acceptance.
    xact(1, 1'b0, 1'b1, 28'h0000009, LINE_B, lat);
    check("l1_wr_latency", 128'(lat), 128'd1);
    xact(1, 1'b1, 1'b0, 28'h0000009, 128'h0, lat);
    check("l1_rd_latency", 128'(lat),       128'd1);
    check("l1_rd_data",    mem_rdata[1],    LINE_B);
    check("l1_wr_cnt",     128'(wr_cnt[1]), 128'd1);

    // LATENCY 255: reset in the 2nd BUSY cycle drops the pending write.
    xact(2, 1'b0, 1'b1, 28'h0000003, OLD3, lat);
    check("l255_wr_latency", 128'(lat), 128'd255);
    mem_write[2] = 1'b1;
    mem_addr[2]  = 28'h0000003;
    mem_wdata[2] = NEW3;
    tick();
    tick();
    rst[2]       = 1'b1;
    mem_write[2] = 1'b0;
    tick();
    rst[2] = 1'b0;
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      if (mem_ready[2]) pulses++;
      tick();
    end
    check("l255_no_ready",  128'(pulses),    128'd0);
    check("l255_wr_cnt",    128'(wr_cnt[2]), 128'd0);
    xact(2, 1'b1, 1'b0, 28'h0000003, 128'h0, lat);
    check("l255_rd_latency", 128'(lat),    128'd255);
    check("l255_array_kept", mem_rdata[2], OLD3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
